// File: rtl/addr_tr_digit_serial.sv
// addr_tr_digit_serial
// Fault-detecting unsigned adder. It computes a + b one DIGIT-bit slice at a
// time. Each slice is evaluated twice: once in true logic (PRI) and once in
// complemented logic (CHK). If the two results disagree, the slice is retried.
// When the shared retry budget runs out, the block reports err and forces sum
// to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid        / in_ready   block can accept operands
//   a, b       WIDTH-bit unsigned operands, sampled on the accept edge
//   inj_mask   DIGIT+1-bit test hook, XORed into the primary slice result
//   out_valid  result valid          / out_ready  downstream takes the result
//   sum        WIDTH+1-bit a + b, zero when err is set
//   err        retry budget exhausted, result untrustworthy
//   retry_cnt  retries consumed by the current/last operation
module addr_tr_digit_serial #(
    parameter  int WIDTH     = 16,
    parameter  int DIGIT     = 4,
    parameter  int MAX_RETRY = 2,
    localparam int NS        = WIDTH / DIGIT,
    localparam int RW        = ($clog2(MAX_RETRY + 1) > 1) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int KW        = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [DIGIT:0]   inj_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err,
    output logic [RW-1:0]    retry_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRI  = 2'd1,
        S_CHK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [DIGIT:0]   r_p;
    logic [WIDTH:0]   r_sum;
    logic             r_err;
    logic [RW-1:0]    r_retry;
    logic [KW-1:0]    r_k;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [DIGIT-1:0] w_a_sl [NS];
    logic [DIGIT-1:0] w_b_sl [NS];
    logic [DIGIT-1:0] w_a_k;
    logic [DIGIT-1:0] w_b_k;
    logic [DIGIT:0]   w_p;
    logic [DIGIT:0]   w_q;
    logic             w_match;
    logic             w_last;
    logic             w_can_retry;
    logic [WIDTH:0]   w_sum_upd;

    // Split the latched operands into slices so that slice k is a plain mux.
    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
        assign w_a_sl[gi] = r_a[gi*DIGIT +: DIGIT];
        assign w_b_sl[gi] = r_b[gi*DIGIT +: DIGIT];
    end

    assign w_a_k = w_a_sl[r_k];
    assign w_b_k = w_b_sl[r_k];

    // Primary adder in true logic. The injection mask models a fault on its output.
    assign w_p = ({1'b0, w_a_k} + {1'b0, w_b_k} + {{DIGIT{1'b0}}, r_c}) ^ inj_mask;

    // Checker adder in complemented logic. Fault free, it yields ~p because
    // ~a + ~b + ~c = 2^(DIGIT+1) - 1 - (a + b + c).
    assign w_q = {1'b0, ~w_a_k} + {1'b0, ~w_b_k} + {{DIGIT{1'b0}}, ~r_c};

    assign w_match     = (~w_q == r_p);
    assign w_last      = (r_k == KW'(NS - 1));
    assign w_can_retry = (r_retry < RW'(MAX_RETRY));

    // Sum register with slice k replaced by the checked result.
    // The final carry goes into the top bit.
    always_comb begin
        w_sum_upd = r_sum;
        for (int i = 0; i < NS; i++) begin
            w_sum_upd[i*DIGIT +: DIGIT] = (r_k == KW'(i)) ? r_p[DIGIT-1:0]
                                                           : r_sum[i*DIGIT +: DIGIT];
        end
        w_sum_upd[WIDTH] = w_last ? r_p[DIGIT] : r_sum[WIDTH];
    end

    // Next-state logic of the control FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_PRI;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PRI: begin
                w_next = S_CHK;
            end
            S_CHK: begin
                if (w_match) begin
                    w_next = w_last ? S_DONE : S_PRI;
                end else if (w_can_retry) begin
                    w_next = S_PRI;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register plus registered handshake outputs, which follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == S_DONE);
            r_in_ready  <= (w_next == S_IDLE);
        end
    end

    // Datapath: operand latch, primary result, carry, slice index, sum, error and retries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_c     <= 1'b0;
            r_p     <= {(DIGIT+1){1'b0}};
            r_sum   <= {(WIDTH+1){1'b0}};
            r_err   <= 1'b0;
            r_retry <= {RW{1'b0}};
            r_k     <= {KW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= 1'b0;
                        r_sum   <= {(WIDTH+1){1'b0}};
                        r_err   <= 1'b0;
                        r_retry <= {RW{1'b0}};
                        r_k     <= {KW{1'b0}};
                    end
                end
                S_PRI: begin
                    r_p <= w_p;
                end
                S_CHK: begin
                    if (w_match) begin
                        r_sum <= w_sum_upd;
                        r_c   <= r_p[DIGIT];
                        if (!w_last) begin
                            r_k <= r_k + KW'(1);
                        end
                    end else if (w_can_retry) begin
                        // Same slice again. The carry is left untouched.
                        r_retry <= r_retry + RW'(1);
                    end else begin
                        r_err <= 1'b1;
                        r_sum <= {(WIDTH+1){1'b0}};
                    end
                end
                S_DONE: begin
                    r_p <= r_p;
                end
                default: begin
                    r_p <= r_p;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign err       = r_err;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_addr_tr_digit_serial.sv
// Directed bench for addr_tr_digit_serial with default parameters.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point.
module tb_addr_tr_digit_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  inj_mask;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] sum;
    logic        err;
    logic [1:0]  retry_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int lat;

    addr_tr_digit_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .inj_mask  (inj_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .err       (err),
        .retry_cnt (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, counting edges since the accept edge. Gives up after 40 edges.
    task automatic wait_done(inout int l);
        while (!out_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic start_op(input logic [15:0] aa, input logic [15:0] bb);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic op_check(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                            input logic [16:0] exp_sum);
        start_op(aa, bb);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        release_out();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        inj_mask  = 5'h00;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Carry ripple and plain sums
        op_check("ripple", 16'hFFFF, 16'h0001, 17'h10000);
        op_check("zero", 16'h0000, 16'h0000, 17'h00000);
        op_check("max", 16'hFFFF, 16'hFFFF, 17'h1FFFE);

        // Transient fault on the first primary evaluation of slice 1
        start_op(16'h1234, 16'h0FF0);
        tick();            // edge 1: slice 0 CHK
        tick();            // edge 2: slice 1 PRI begins
        inj_mask = 5'h01;
        tick();            // edge 3: the faulty primary result is captured
        inj_mask = 5'h00;
        lat = 3;
        wait_done(lat);
        chk("transient_latency", 32'(lat), 32'd10);
        chk("transient_sum", 32'(sum), 32'h2224);
        chk("transient_err", 32'(err), 32'd0);
        chk("transient_retry", 32'(retry_cnt), 32'd1);
        release_out();

        // Permanent fault: slice 0 never matches
        inj_mask = 5'h10;
        start_op(16'h1234, 16'h0FF0);
        wait_done(lat);
        inj_mask = 5'h00;
        chk("perm_latency", 32'(lat), 32'd6);
        chk("perm_sum", 32'(sum), 32'd0);
        chk("perm_err", 32'(err), 32'd1);
        chk("perm_retry", 32'(retry_cnt), 32'd2);
        release_out();

        // Backpressure in DONE while the inputs toggle
        start_op(16'h1111, 16'h2222);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a        = 16'hAAAA ^ 16'(i);
            b        = 16'h5555 + 16'(i);
            tick();
            chk("bp_sum_stable", 32'(sum), 32'h3333);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_err", 32'(err), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        op_check("after_bp", 16'h0F0F, 16'h0101, 17'h01010);

        // Asynchronous reset during CHK of slice 2
        start_op(16'h1234, 16'h1111);
        for (int i = 0; i < 5; i++) begin
            tick();        // after edge 5 the block is in slice 2 CHK
        end
        chk("mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_retry", 32'(retry_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        op_check("after_rst", 16'h00FF, 16'h0001, 17'h00100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
